// File: rtl/scoreboard_pkg.sv
// Constants and types shared between score_keeper and display_simple_controller.
package scoreboard_pkg;

   localparam int unsigned SCORE_W    = 8;
   localparam int unsigned HIST_CNT_W = 4;

   localparam logic [SCORE_W-1:0] MAX_SCORE_DEFAULT = 8'd99;

   localparam logic PLAYER_1 = 1'b0;
   localparam logic PLAYER_2 = 1'b1;

   localparam logic [3:0] BLANK_CODE = 4'b1111;

   // One-cycle press pulses from the four debounced buttons.
   typedef struct packed {
      logic p1;
      logic p2;
      logic undo;
      logic clear;
   } press_t;

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-FF synchronizer -> level debouncer -> registered rising-edge pulse.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q;
   logic             level_prev_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], btn_i};
      end
   end

   // Any sample matching the accepted level restarts the count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else if (sync_q[1] == level_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         level_q <= ~level_q;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_prev_q <= 1'b0;
         press_o      <= 1'b0;
      end else begin
         level_prev_q <= level_q;
         press_o      <= level_q & ~level_prev_q;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Debounces four buttons and keeps two saturating scores with a LIFO undo history.
module score_keeper
   import scoreboard_pkg::*;
#(
   parameter int unsigned        DEBOUNCE_CYCLES = 500000,
   parameter logic [SCORE_W-1:0] MAX_SCORE       = MAX_SCORE_DEFAULT,
   parameter int unsigned        HIST_DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  btn_p1_i,
   input  logic                  btn_p2_i,
   input  logic                  btn_undo_i,
   input  logic                  btn_clear_i,
   output logic [SCORE_W-1:0]    p1_score_o,
   output logic [SCORE_W-1:0]    p2_score_o,
   output logic [HIST_CNT_W-1:0] hist_count_o,
   output logic                  event_o
);

   localparam logic [HIST_CNT_W-1:0] DEPTH_CNT = HIST_CNT_W'(HIST_DEPTH);

   press_t press;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_p1_i), .press_o(press.p1)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_p2_i), .press_o(press.p2)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_undo (
      .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_undo_i), .press_o(press.undo)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_clear_i), .press_o(press.clear)
   );

   // Bit 0 of the stack is the newest entry; pushes shift the oldest out the top.
   logic [HIST_DEPTH-1:0] stack_q;
   logic [HIST_DEPTH-1:0] stack_d;
   logic [HIST_CNT_W-1:0] count_d;
   logic [SCORE_W-1:0]    p1_d;
   logic [SCORE_W-1:0]    p2_d;
   logic                  event_d;

   always_comb begin
      p1_d    = p1_score_o;
      p2_d    = p2_score_o;
      count_d = hist_count_o;
      stack_d = stack_q;
      event_d = 1'b0;

      if (press.clear) begin
         p1_d    = '0;
         p2_d    = '0;
         count_d = '0;
         event_d = (p1_score_o != '0) || (p2_score_o != '0);
      end else if (press.undo) begin
         if (hist_count_o != '0) begin
            if (stack_q[0] == PLAYER_1) begin
               p1_d = p1_score_o - SCORE_W'(1);
            end else begin
               p2_d = p2_score_o - SCORE_W'(1);
            end
            stack_d = {1'b0, stack_q[HIST_DEPTH-1:1]};
            count_d = hist_count_o - HIST_CNT_W'(1);
            event_d = 1'b1;
         end
      end else if (press.p1 && press.p2) begin
         event_d = 1'b0;
      end else if (press.p1) begin
         if (p1_score_o < MAX_SCORE) begin
            p1_d    = p1_score_o + SCORE_W'(1);
            stack_d = {stack_q[HIST_DEPTH-2:0], PLAYER_1};
            count_d = (hist_count_o == DEPTH_CNT) ? hist_count_o
                                                  : hist_count_o + HIST_CNT_W'(1);
            event_d = 1'b1;
         end
      end else if (press.p2) begin
         if (p2_score_o < MAX_SCORE) begin
            p2_d    = p2_score_o + SCORE_W'(1);
            stack_d = {stack_q[HIST_DEPTH-2:0], PLAYER_2};
            count_d = (hist_count_o == DEPTH_CNT) ? hist_count_o
                                                  : hist_count_o + HIST_CNT_W'(1);
            event_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p1_score_o   <= '0;
         p2_score_o   <= '0;
         hist_count_o <= '0;
         stack_q      <= '0;
         event_o      <= 1'b0;
      end else begin
         p1_score_o   <= p1_d;
         p2_score_o   <= p2_d;
         hist_count_o <= count_d;
         stack_q      <= stack_d;
         event_o      <= event_d;
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus queues expected results, a monitor checks each event.
module tb_score_keeper;

   localparam int unsigned DC = 4;
   localparam int unsigned HD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn = 4'b0000;   // {clear, undo, p2, p1}
   logic [7:0] p1_score;
   logic [7:0] p2_score;
   logic [3:0] hist_count;
   logic       event_pulse;

   score_keeper #(
      .DEBOUNCE_CYCLES(DC),
      .MAX_SCORE      (8'd99),
      .HIST_DEPTH     (HD)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .btn_p1_i    (btn[0]),
      .btn_p2_i    (btn[1]),
      .btn_undo_i  (btn[2]),
      .btn_clear_i (btn[3]),
      .p1_score_o  (p1_score),
      .p2_score_o  (p2_score),
      .hist_count_o(hist_count),
      .event_o     (event_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p1;
      int p2;
      int hist;
      int cyc;   // 0 = arrival cycle not checked
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every event pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n && event_pulse) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("event_p1", int'(p1_score), e.p1);
            chk("event_p2", int'(p2_score), e.p2);
            chk("event_hist", int'(hist_count), e.hist);
            if (e.cyc != 0) chk("event_latency", cyc, e.cyc);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raw edge driven mid-cycle c; first sampling edge is cycle c+1, score lands 7 edges later.
   task automatic tap(input logic [3:0] m, input bit ev, input int p1, input int p2, input int h);
      @(negedge clk);
      if (ev) exp_q.push_back('{p1, p2, h, cyc + 8});
      btn = m;
      wait_cyc(10);
      btn = 4'b0000;
      wait_cyc(10);
   endtask

   initial begin
      wait_cyc(3);
      chk("reset_p1", int'(p1_score), 0);
      chk("reset_p2", int'(p2_score), 0);
      chk("reset_hist", int'(hist_count), 0);
      chk("reset_event", int'(event_pulse), 0);
      rst_n = 1'b1;
      wait_cyc(3);

      // Clean press with latency check
      tap(4'b0001, 1, 1, 0, 1);
      chk("clean_p1", int'(p1_score), 1);
      chk("clean_hist", int'(hist_count), 1);

      // Bounced p2 press: one increment only
      @(negedge clk);
      exp_q.push_back('{1, 1, 2, 0});
      btn[1] = 1'b1; wait_cyc(3);
      btn[1] = 1'b0; wait_cyc(1);
      btn[1] = 1'b1; wait_cyc(10);
      btn[1] = 1'b0; wait_cyc(10);
      chk("bounce_p2", int'(p2_score), 1);

      // 3-cycle glitch alone is rejected
      @(negedge clk);
      btn[1] = 1'b1; wait_cyc(3);
      btn[1] = 1'b0; wait_cyc(12);
      chk("glitch_p2", int'(p2_score), 1);
      chk("glitch_hist", int'(hist_count), 2);

      // Saturation
      tap(4'b1000, 1, 0, 0, 0);
      for (int k = 1; k <= 99; k++) tap(4'b0001, 1, k, 0, (k < 4) ? k : 4);
      chk("sat_99", int'(p1_score), 99);
      tap(4'b0001, 0, 0, 0, 0);
      chk("sat_hold", int'(p1_score), 99);
      chk("sat_hist", int'(hist_count), 4);

      // LIFO undo: history newest-first is p2,p2,p1,p2 after the oldest p1 falls out
      tap(4'b1000, 1, 0, 0, 0);
      tap(4'b0001, 1, 1, 0, 1);
      tap(4'b0010, 1, 1, 1, 2);
      tap(4'b0001, 1, 2, 1, 3);
      tap(4'b0010, 1, 2, 2, 4);
      tap(4'b0010, 1, 2, 3, 4);
      chk("undo_full_hist", int'(hist_count), 4);
      tap(4'b0100, 1, 2, 2, 3);
      tap(4'b0100, 1, 2, 1, 2);
      tap(4'b0100, 1, 1, 1, 1);
      tap(4'b0100, 1, 1, 0, 0);
      tap(4'b0100, 0, 0, 0, 0);
      chk("undo_empty_p1", int'(p1_score), 1);
      chk("undo_empty_p2", int'(p2_score), 0);
      chk("undo_empty_hist", int'(hist_count), 0);

      // Simultaneous p1+p2 ignored
      tap(4'b0011, 0, 0, 0, 0);
      chk("both_p1", int'(p1_score), 1);
      chk("both_p2", int'(p2_score), 0);
      chk("both_hist", int'(hist_count), 0);

      // clear beats undo
      tap(4'b0010, 1, 1, 1, 1);
      tap(4'b1100, 1, 0, 0, 0);
      chk("clr_undo_p1", int'(p1_score), 0);
      chk("clr_undo_hist", int'(hist_count), 0);

      // Async reset mid-debounce; held button counts once afterwards
      tap(4'b0010, 1, 0, 1, 1);
      @(negedge clk);
      btn[0] = 1'b1;
      wait_cyc(4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_p2", int'(p2_score), 0);
      chk("async_rst_hist", int'(hist_count), 0);
      chk("async_rst_event", int'(event_pulse), 0);
      wait_cyc(3);
      rst_n = 1'b1;
      exp_q.push_back('{1, 0, 1, cyc + 8});
      wait_cyc(12);
      btn = 4'b0000;
      wait_cyc(12);
      chk("post_rst_p1", int'(p1_score), 1);

      chk("pending_expectations", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
